sdram_tester: RTL and testbench

Request sequencer that sits directly upstream of the SDRAM controller and drives its processor-side port (address, write data, write/read enables, returned data, ack). On a start pulse it writes a deterministic pattern to a contiguous range of words and then reads the range back. It compares each read against the expected pattern and reports pass/fail, the error count, the first failing address and a timeout flag. Status outputs go to LEDR/HEX on the board top.

---
 rtl/sdram_tester_pkg.sv | 12 +
 rtl/sdram_req_timer.sv | 14 +
 rtl/sdram_tester.sv | 131 +++++++++++++
 tb/tb_sdram_tester.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sdram_tester_pkg.sv
// sdram_tester_pkg: FSM state encoding and the write/read test pattern shared by the tester.
package sdram_tester_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN} state_t;
  // seed ^ {~a, a} built for an aw-bit address; callers truncate to their data width
  function automatic logic [127:0] pattern(input logic [63:0] addr, input logic [127:0] seed, input int aw);
    logic [63:0] mask;
    logic [63:0] a;
    mask = (64'd1 << aw) - 64'd1;
    a = addr & mask;
    return seed ^ (({64'd0, ~a & mask} << aw) | {64'd0, a});
  endfunction
endpackage

// File: rtl/sdram_req_timer.sv
// sdram_req_timer: counts cycles a request has waited; expired on the last allowed cycle.
module sdram_req_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic sys_clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] count;
  always_ff @(posedge sys_clk) count <= clear ? '0 : enable ? count + 1'b1 : count;
  assign expired = enable && count == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/sdram_tester.sv
// sdram_tester: writes a seeded pattern to a word range through the controller port, reads it back and reports status.
module sdram_tester
  import sdram_tester_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  we_o,
  output logic                  re_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [ADDR_WIDTH-1:0] err_count_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o
);
  state_t state, state_n;
  logic [ADDR_WIDTH:0] idx, idx_n;
  logic [ADDR_WIDTH-1:0] len_q, len_n, err_n, fe_n;
  logic [DATA_WIDTH-1:0] seed_q, seed_n, pat_cur, pat_n;
  logic to_n, done_n, pass_n, busy_n, in_req, expired, last;
  assign in_req = state == WR_REQ || state == RD_REQ;
  assign last = idx == {1'b0, len_q};
  assign pat_cur = DATA_WIDTH'(pattern(64'(idx[ADDR_WIDTH-1:0]), 128'(seed_q), ADDR_WIDTH));
  assign pat_n = DATA_WIDTH'(pattern(64'(idx_n[ADDR_WIDTH-1:0]), 128'(seed_n), ADDR_WIDTH));
  sdram_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .sys_clk(sys_clk),
    .clear(!sys_rst_n || !in_req),
    .enable(in_req),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    len_n = len_q;
    seed_n = seed_q;
    err_n = err_count_o;
    fe_n = first_err_addr_o;
    to_n = timeout_o;
    done_n = done_o;
    pass_n = pass_o;
    busy_n = busy_o;
    case (state)
      IDLE: if (start_i) begin
        len_n = len_i;
        seed_n = seed_i;
        idx_n = '0;
        err_n = '0;
        fe_n = '0;
        to_n = 1'b0;
        done_n = 1'b0;
        pass_n = 1'b0;
        busy_n = 1'b1;
        state_n = len_i == '0 ? FIN : WR_REQ;
      end
      WR_REQ: if (ack_i) begin
        idx_n = idx + 1'b1;
        state_n = WR_GAP;
      end else if (expired) begin
        to_n = 1'b1;
        state_n = FIN;
      end
      WR_GAP: begin
        idx_n = last ? '0 : idx;
        state_n = last ? RD_REQ : WR_REQ;
      end
      RD_REQ: if (ack_i) begin
        if (data_i != pat_cur) begin
          err_n = &err_count_o ? err_count_o : err_count_o + 1'b1;
          fe_n = err_count_o == '0 ? idx[ADDR_WIDTH-1:0] : first_err_addr_o;
        end
        idx_n = idx + 1'b1;
        state_n = RD_GAP;
      end else if (expired) begin
        to_n = 1'b1;
        state_n = FIN;
      end
      RD_GAP: state_n = last ? FIN : RD_REQ;
      default: state_n = IDLE;
    endcase
    // status settles on the edge that enters FIN so done/busy move one cycle after the final ack
    if (state_n == FIN) begin
      done_n = 1'b1;
      busy_n = 1'b0;
      pass_n = err_n == '0 && !to_n;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      idx <= '0;
      len_q <= '0;
      seed_q <= '0;
      addr_o <= '0;
      data_o <= '0;
      we_o <= 1'b0;
      re_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      pass_o <= 1'b0;
      timeout_o <= 1'b0;
      err_count_o <= '0;
      first_err_addr_o <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      len_q <= len_n;
      seed_q <= seed_n;
      addr_o <= (state_n == WR_REQ || state_n == RD_REQ) ? idx_n[ADDR_WIDTH-1:0] : '0;
      data_o <= state_n == WR_REQ ? pat_n : '0;
      we_o <= state_n == WR_REQ;
      re_o <= state_n == RD_REQ;
      busy_o <= busy_n;
      done_o <= done_n;
      pass_o <= pass_n;
      timeout_o <= to_n;
      err_count_o <= err_n;
      first_err_addr_o <= fe_n;
    end
  end
endmodule

// File: tb/tb_sdram_tester.sv
// tb_sdram_tester: bus/memory model with latency, scoreboard queues of expected writes and reads.
module tb_sdram_tester;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, start_i = 1'b0, ack_i = 1'b0;
  logic [15:0] len_i = '0, addr_o, err_count_o, first_err_addr_o;
  logic [31:0] seed_i = '0, data_o, data_i = '0;
  logic we_o, re_o, busy_o, done_o, pass_o, timeout_o;
  int total = 0, bad = 0;
  int lat = 2, cnt = 0, reqs = 0, viol = 0;
  logic no_ack = 1'b0;
  logic [15:0] corrupt_addr = 16'hFFFF;
  logic [31:0] mem [0:255];
  logic [47:0] wq [$], exp_w [$];
  logic [15:0] rq [$], exp_r [$];

  sdram_tester #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_i(start_i), .len_i(len_i), .seed_i(seed_i),
    .addr_o(addr_o), .data_o(data_o), .we_o(we_o), .re_o(re_o), .data_i(data_i), .ack_i(ack_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] exp_pat(input logic [15:0] a, input logic [31:0] s);
    return s ^ {~a, a};
  endfunction

  // controller model: acks lat cycles after request assertion, records observed transactions
  always @(negedge sys_clk) begin
    if (we_o || re_o) reqs++;
    if ((we_o && re_o) || (ack_i && (we_o || re_o))) viol++;
    if (!sys_rst_n || ack_i) begin
      ack_i = 1'b0;
      cnt = 0;
    end else if ((we_o || re_o) && !no_ack) begin
      if (cnt == lat - 1) begin
        ack_i = 1'b1;
        cnt = 0;
        if (we_o) begin
          mem[addr_o[7:0]] = data_o;
          wq.push_back({addr_o, data_o});
        end else begin
          data_i = mem[addr_o[7:0]] ^ {31'd0, addr_o == corrupt_addr};
          rq.push_back(addr_o);
        end
      end else cnt++;
    end
  end

  task automatic start_run(input logic [15:0] len, input logic [31:0] seed);
    wq.delete(); rq.delete(); exp_w.delete(); exp_r.delete();
    for (int a = 0; a < int'(len); a++) begin
      exp_w.push_back({16'(a), exp_pat(16'(a), seed)});
      exp_r.push_back(16'(a));
    end
    reqs = 0;
    viol = 0;
    @(negedge sys_clk);
    len_i = len;
    seed_i = seed;
    start_i = 1'b1;
    @(negedge sys_clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (!done_o) begin bad++; $display("FAIL wait_done: done_o never rose within %0d cycles", n); end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    total++; if ({we_o, re_o, busy_o, done_o, pass_o, timeout_o} !== 6'b0) begin bad++; $display("FAIL reset_flags: got %b want 000000", {we_o, re_o, busy_o, done_o, pass_o, timeout_o}); end
    total++; if (addr_o !== 16'd0 || data_o !== 32'd0) begin bad++; $display("FAIL reset_bus: addr=%h data=%h want 0", addr_o, data_o); end
    total++; if (err_count_o !== 16'd0 || first_err_addr_o !== 16'd0) begin bad++; $display("FAIL reset_err: cnt=%h first=%h want 0", err_count_o, first_err_addr_o); end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_clean();
    logic [47:0] e, o;
    start_run(16'd4, 32'd0);
    total++; if (we_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL clean_first_we: we=%b busy=%b want 1 1", we_o, busy_o); end
    wait_done();
    total++; if (wq.size() !== 4) begin bad++; $display("FAIL clean_wr_count: got %0d want 4", wq.size()); end
    total++; if (wq.size() > 1 && wq[1] !== {16'd1, 32'hFFFE0001}) begin bad++; $display("FAIL clean_addr1: got %h want 0001fffe0001", wq[1]); end
    while (exp_w.size() > 0) begin
      e = exp_w.pop_front();
      o = wq.size() > 0 ? wq.pop_front() : 48'hx;
      total++; if (o !== e) begin bad++; $display("FAIL clean_write: got %h want %h", o, e); end
    end
    total++; if (rq !== exp_r) begin bad++; $display("FAIL clean_reads: got %p want %p", rq, exp_r); end
    total++; if ({done_o, pass_o, busy_o, timeout_o} !== 4'b1100 || err_count_o !== 16'd0) begin bad++; $display("FAIL clean_status: dpbt=%b err=%0d want 1100 0", {done_o, pass_o, busy_o, timeout_o}, err_count_o); end
    total++; if (viol !== 0) begin bad++; $display("FAIL clean_handshake: violations=%0d want 0", viol); end
  endtask

  task automatic test_corrupt();
    corrupt_addr = 16'd2;
    start_run(16'd4, 32'h1234_5678);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL corrupt_done_clear: got %b want 0", done_o); end
    wait_done();
    corrupt_addr = 16'hFFFF;
    total++; if (err_count_o !== 16'd1 || first_err_addr_o !== 16'd2) begin bad++; $display("FAIL corrupt_err: cnt=%0d first=%0d want 1 2", err_count_o, first_err_addr_o); end
    total++; if (pass_o !== 1'b0 || timeout_o !== 1'b0) begin bad++; $display("FAIL corrupt_pass: pass=%b to=%b want 0 0", pass_o, timeout_o); end
  endtask

  task automatic test_timeout();
    int n = 0;
    no_ack = 1'b1;
    start_run(16'd4, 32'd7);
    while (we_o && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    no_ack = 1'b0;
    total++; if (n !== 16) begin bad++; $display("FAIL timeout_len: we_o high %0d cycles want 16", n); end
    total++; if ({timeout_o, done_o, pass_o, busy_o, re_o} !== 5'b11000) begin bad++; $display("FAIL timeout_status: tdpbr=%b want 11000", {timeout_o, done_o, pass_o, busy_o, re_o}); end
  endtask

  task automatic test_zero_len();
    int n = 0;
    start_run(16'd0, 32'hDEAD_BEEF);
    while (!done_o && n < 2) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (3) @(negedge sys_clk);
    total++; if (done_o !== 1'b1 || pass_o !== 1'b1) begin bad++; $display("FAIL zero_status: done=%b pass=%b (after %0d) want 1 1", done_o, pass_o, n); end
    total++; if (reqs !== 0) begin bad++; $display("FAIL zero_reqs: got %0d want 0", reqs); end
  endtask

  task automatic test_disturb();
    int n = 0;
    start_run(16'd4, 32'hA5A5_5A5A);
    repeat (4) @(negedge sys_clk);
    len_i = 16'd1;
    start_i = 1'b1;
    @(negedge sys_clk);
    start_i = 1'b0;
    while (!re_o && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    total++; if (re_o !== 1'b1) begin bad++; $display("FAIL disturb_reach_read: re_o=%b want 1", re_o); end
    total++; if (wq.size() !== 4 || wq[0][47:32] !== 16'd0 || wq[3][47:32] !== 16'd3) begin bad++; $display("FAIL disturb_ignored: writes=%0d want 4 to 0..3", wq.size()); end
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    total++; if ({re_o, we_o, busy_o, done_o} !== 4'b0 || addr_o !== 16'd0) begin bad++; $display("FAIL disturb_reset: rwbd=%b addr=%h want 0000 0", {re_o, we_o, busy_o, done_o}, addr_o); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    start_run(16'd3, 32'h0F0F_0F0F);
    wait_done();
    total++; if (pass_o !== 1'b1 || wq.size() !== 3 || rq !== exp_r) begin bad++; $display("FAIL disturb_restart: pass=%b writes=%0d reads=%0d want 1 3 3", pass_o, wq.size(), rq.size()); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corrupt();
    test_timeout();
    test_zero_len();
    test_disturb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
